// File: rtl/rsaasip_mem_pkg.sv
// Shared types and widths for the data-memory port arbiter.
//   memarb_state_t : arbiter FSM states (IDLE, PIPE_RD, DMA_RD)
//   LAT_CNT_W      : width of the read-latency counter
//   STARVE_CNT_W   : width of the DMA starvation counter
package rsaasip_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PIPE_RD,
        DMA_RD
    } memarb_state_t;

    localparam int unsigned LAT_CNT_W    = 3;
    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Sequences the single data-memory port between the MEM pipeline stage and a
// DMA/loader requester. Writes complete in their issue cycle; reads hold the
// port for MEM_LAT cycles and complete with data passed straight through from
// mem_rdata. A starvation counter lets DMA win after STARVE_MAX lost rounds.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pipe_rd/wr/addr/wdata    MEM-stage request (held until pipe_done)
//   pipe_stall/done/rdata    pipeline freeze, completion pulse, read data
//   dma_req/we/addr/wdata    DMA request (held until dma_gnt)
//   dma_gnt/rvalid/rdata     DMA accept pulse, read-data pulse, read data
//   mem_re/we/addr/wdata     RAM strobes and address/data (0 when idle)
//   mem_rdata                RAM read data, valid MEM_LAT cycles after mem_re
module mem_port_arbiter
    import rsaasip_mem_pkg::*;
#(
    parameter int unsigned ARQ        = 16,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pipe_rd,
    input  logic           pipe_wr,
    input  logic [ARQ-1:0] pipe_addr,
    input  logic [ARQ-1:0] pipe_wdata,
    output logic           pipe_stall,
    output logic           pipe_done,
    output logic [ARQ-1:0] pipe_rdata,
    input  logic           dma_req,
    input  logic           dma_we,
    input  logic [ARQ-1:0] dma_addr,
    input  logic [ARQ-1:0] dma_wdata,
    output logic           dma_gnt,
    output logic           dma_rvalid,
    output logic [ARQ-1:0] dma_rdata,
    output logic           mem_re,
    output logic           mem_we,
    output logic [ARQ-1:0] mem_addr,
    output logic [ARQ-1:0] mem_wdata,
    input  logic [ARQ-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0]    LAT_ONE    = LAT_CNT_W'(1);
    localparam logic [LAT_CNT_W-1:0]    LAT_LAST   = LAT_CNT_W'(MEM_LAT);
    localparam logic [STARVE_CNT_W-1:0] STARVE_ONE = STARVE_CNT_W'(1);
    localparam logic [STARVE_CNT_W-1:0] STARVE_TOP = STARVE_CNT_W'(STARVE_MAX);

    memarb_state_t             state_q, state_d;
    logic [LAT_CNT_W-1:0]      lat_q, lat_d;
    logic [STARVE_CNT_W-1:0]   starve_q, starve_d;

    logic pipe_req;
    logic dma_win;

    assign pipe_req = pipe_rd | pipe_wr;
    // DMA takes the port when alone, or when it has lost STARVE_MAX rounds.
    assign dma_win  = dma_req & (~pipe_req | (starve_q == STARVE_TOP));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        pipe_stall = 1'b0;
        pipe_done  = 1'b0;
        pipe_rdata = '0;
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        // Outputs are forced low during reset; the register reset handles state.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (dma_win) begin
                        dma_gnt  = 1'b1;
                        starve_d = '0;
                        mem_addr = dma_addr;
                        if (dma_we) begin
                            mem_we    = 1'b1;
                            mem_wdata = dma_wdata;
                        end else begin
                            mem_re  = 1'b1;
                            lat_d   = LAT_ONE;
                            state_d = DMA_RD;
                        end
                    end else if (pipe_req) begin
                        mem_addr = pipe_addr;
                        if (!dma_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_TOP) begin
                            starve_d = starve_q + STARVE_ONE;
                        end
                        if (pipe_wr) begin
                            mem_we    = 1'b1;
                            mem_wdata = pipe_wdata;
                            pipe_done = 1'b1;
                        end else begin
                            mem_re  = 1'b1;
                            lat_d   = LAT_ONE;
                            state_d = PIPE_RD;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end

                PIPE_RD, DMA_RD: begin
                    // Starvation count is frozen while a read is in flight.
                    if (!dma_req) begin
                        starve_d = '0;
                    end
                    if (lat_q == LAT_LAST) begin
                        lat_d   = '0;
                        state_d = IDLE;
                        if (state_q == PIPE_RD) begin
                            pipe_done  = 1'b1;
                            pipe_rdata = mem_rdata;
                        end else begin
                            dma_rvalid = 1'b1;
                            dma_rdata  = mem_rdata;
                        end
                    end else begin
                        lat_d = lat_q + LAT_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    lat_d   = '0;
                end
            endcase

            pipe_stall = pipe_req & ~pipe_done;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
// A transaction-level model tracks the port owner by absolute completion cycle
// and counts lost DMA rounds; a separate RAM model answers the DUT's strobes.
module tb_mem_port_arbiter;

    localparam int unsigned ARQ        = 16;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          NCYC       = 2400;

    logic           clk = 1'b0;
    logic           rst;
    logic           pipe_rd, pipe_wr;
    logic [ARQ-1:0] pipe_addr, pipe_wdata;
    logic           pipe_stall, pipe_done;
    logic [ARQ-1:0] pipe_rdata;
    logic           dma_req, dma_we;
    logic [ARQ-1:0] dma_addr, dma_wdata;
    logic           dma_gnt, dma_rvalid;
    logic [ARQ-1:0] dma_rdata;
    logic           mem_re, mem_we;
    logic [ARQ-1:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ARQ       (ARQ),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_rd   (pipe_rd),
        .pipe_wr   (pipe_wr),
        .pipe_addr (pipe_addr),
        .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .pipe_done (pipe_done),
        .pipe_rdata(pipe_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_rdata (dma_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // RAM seen by the DUT, and the model's own copy.
    logic [ARQ-1:0] ram  [0:255];
    logic [ARQ-1:0] mram [0:255];
    bit             env_pend = 1'b0;
    int             env_rd_cyc = 0;
    logic [7:0]     env_rd_addr = '0;

    // Outstanding requests from each side.
    bit             p_act = 1'b0, p_wr = 1'b0;
    logic [ARQ-1:0] p_addr = '0, p_wdata = '0;
    bit             d_act = 1'b0, d_we = 1'b0;
    logic [ARQ-1:0] d_addr = '0, d_wdata = '0;

    // Port ownership: a read in flight completes at an absolute cycle number.
    bit             m_busy = 1'b0, m_owner_dma = 1'b0;
    int             m_done_cyc = 0;
    logic [7:0]     m_raddr = '0;
    int             m_lost = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_cycle(input bit r, input int p_pct, input int d_pct, input bit wr_only);
        bit             e_stall, e_pdone, e_gnt, e_rv, e_re, e_we;
        logic [ARQ-1:0] e_prdata, e_drdata, e_addr, e_wdata;
        bit             n_busy, n_owner, retire_p, retire_d;
        int             n_done, n_lost;
        logic [7:0]     n_raddr;

        @(negedge clk);
        rst        = r;
        pipe_rd    = p_act && !p_wr;
        pipe_wr    = p_act && p_wr;
        pipe_addr  = p_act ? p_addr  : ARQ'($urandom);
        pipe_wdata = p_act ? p_wdata : ARQ'($urandom);
        dma_req    = d_act;
        dma_we     = d_act ? d_we : 1'($urandom);
        dma_addr   = d_act ? d_addr  : ARQ'($urandom);
        dma_wdata  = d_act ? d_wdata : ARQ'($urandom);
        if (env_pend && cyc == env_rd_cyc + int'(MEM_LAT)) begin
            mem_rdata = ram[env_rd_addr];
            env_pend  = 1'b0;
        end else begin
            mem_rdata = ARQ'($urandom);
        end

        e_stall = 0; e_pdone = 0; e_gnt = 0; e_rv = 0; e_re = 0; e_we = 0;
        e_prdata = '0; e_drdata = '0; e_addr = '0; e_wdata = '0;
        n_busy = m_busy; n_owner = m_owner_dma; n_done = m_done_cyc;
        n_raddr = m_raddr; n_lost = m_lost; retire_p = 0; retire_d = 0;

        if (r) begin
            n_busy = 0;
            n_lost = 0;
        end else begin
            if (m_busy) begin
                if (cyc == m_done_cyc) begin
                    n_busy = 0;
                    if (m_owner_dma) begin
                        e_rv = 1; e_drdata = mram[m_raddr];
                    end else begin
                        e_pdone = 1; e_prdata = mram[m_raddr]; retire_p = 1;
                    end
                end
                if (!d_act) n_lost = 0;
            end else if (d_act && (!p_act || m_lost >= int'(STARVE_MAX))) begin
                e_gnt = 1; retire_d = 1; n_lost = 0; e_addr = d_addr;
                if (d_we) begin
                    e_we = 1; e_wdata = d_wdata;
                end else begin
                    e_re = 1; n_busy = 1; n_owner = 1;
                    n_done = cyc + int'(MEM_LAT); n_raddr = d_addr[7:0];
                end
            end else if (p_act) begin
                e_addr = p_addr;
                n_lost = !d_act ? 0 : (m_lost < int'(STARVE_MAX) ? m_lost + 1 : m_lost);
                if (p_wr) begin
                    e_we = 1; e_wdata = p_wdata; e_pdone = 1; retire_p = 1;
                end else begin
                    e_re = 1; n_busy = 1; n_owner = 0;
                    n_done = cyc + int'(MEM_LAT); n_raddr = p_addr[7:0];
                end
            end else begin
                n_lost = 0;
            end
            e_stall = p_act && !e_pdone;
        end

        #1;
        check_val("pipe_stall", 32'(pipe_stall), 32'(e_stall));
        check_val("pipe_done",  32'(pipe_done),  32'(e_pdone));
        check_val("pipe_rdata", 32'(pipe_rdata), 32'(e_prdata));
        check_val("dma_gnt",    32'(dma_gnt),    32'(e_gnt));
        check_val("dma_rvalid", 32'(dma_rvalid), 32'(e_rv));
        check_val("dma_rdata",  32'(dma_rdata),  32'(e_drdata));
        check_val("mem_re",     32'(mem_re),     32'(e_re));
        check_val("mem_we",     32'(mem_we),     32'(e_we));
        check_val("mem_addr",   32'(mem_addr),   32'(e_addr));
        check_val("mem_wdata",  32'(mem_wdata),  32'(e_wdata));

        // RAM environment reacts to what the DUT actually drove.
        if (mem_re === 1'b1) begin
            env_pend    = 1'b1;
            env_rd_cyc  = cyc;
            env_rd_addr = mem_addr[7:0];
        end
        if (mem_we === 1'b1) ram[mem_addr[7:0]] = mem_wdata;

        if (!r && e_we) mram[e_addr[7:0]] = e_wdata;
        m_busy = n_busy; m_owner_dma = n_owner; m_done_cyc = n_done;
        m_raddr = n_raddr; m_lost = n_lost;
        if (retire_p) p_act = 1'b0;
        if (retire_d) d_act = 1'b0;

        if (!p_act && $urandom_range(0, 99) < p_pct) begin
            p_act   = 1'b1;
            p_wr    = wr_only ? 1'b1 : 1'($urandom);
            p_addr  = 16'h0010 + ARQ'($urandom_range(0, 31));
            p_wdata = ARQ'($urandom);
        end
        if (!d_act && $urandom_range(0, 99) < d_pct) begin
            d_act   = 1'b1;
            d_we    = 1'($urandom);
            d_addr  = 16'h0010 + ARQ'($urandom_range(0, 31));
            d_wdata = ARQ'($urandom);
        end
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 16'hA500 ^ 16'(i * 37);
            mram[i] = 16'hA500 ^ 16'(i * 37);
        end
        ram[8'h10]  = 16'hBEEF;
        mram[8'h10] = 16'hBEEF;
        rst = 1'b1;
        pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;

        for (int i = 0; i < NCYC; i++) begin
            bit r;
            r = (i < 3) || ($urandom_range(0, 79) == 0);
            if (i < 800)       do_cycle(r, 40, 30, 1'b0);
            else if (i < 1300) do_cycle(r, 100, 100, 1'b1);
            else               do_cycle(r, 70, 50, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
